// File: rtl/iddr_tap_calib.sv
// iddr_tap_calib: sweeps the input-delay tap, finds the widest passing window and loads its centre.
// Optional macro IDDR_TAP_CALIB_TRACK_EN: keep checking in DONE and re-sweep on loss of lock.
`default_nettype none

module iddr_tap_calib #(
  parameter int              WIDTH         = 1,
  parameter int              TAP_WIDTH     = 5,
  parameter int              SETTLE_CYCLES = 16,
  parameter int              SAMPLE_COUNT  = 256,
  parameter int              MIN_WINDOW    = 2,
  parameter int              DEFAULT_TAP   = 0,
  parameter logic [WIDTH-1:0] PATTERN_Q1   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] PATTERN_Q2   = {WIDTH{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     q1_i,
  input  logic [WIDTH-1:0]     q2_i,
  output logic [TAP_WIDTH-1:0] tap_out_o,
  output logic                 tap_load_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 locked_o,
  output logic                 error_o,
  output logic [TAP_WIDTH-1:0] win_start_o,
  output logic [TAP_WIDTH:0]   win_len_o
);

  localparam int N       = 1 << TAP_WIDTH;
  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_COUNT) ? SETTLE_CYCLES : SAMPLE_COUNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     SAMPLE_LAST = CNT_W'(SAMPLE_COUNT - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE     = CNT_W'(1);
  localparam logic [TAP_WIDTH-1:0] TAP_ONE     = TAP_WIDTH'(1);
  localparam logic [TAP_WIDTH-1:0] LAST_TAP    = TAP_WIDTH'(N - 1);
  localparam logic [TAP_WIDTH-1:0] DEF_TAP     = TAP_WIDTH'(DEFAULT_TAP);
  localparam logic [TAP_WIDTH:0]   LEN_ONE     = (TAP_WIDTH + 1)'(1);
  localparam logic [TAP_WIDTH:0]   MIN_LEN     = (TAP_WIDTH + 1)'(MIN_WINDOW);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SET_TAP = 3'd1,
    S_SETTLE  = 3'd2,
    S_SAMPLE  = 3'd3,
    S_EVAL    = 3'd4,
    S_APPLY   = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [TAP_WIDTH-1:0] cur_tap_q, cur_tap_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 fail_q, fail_d;
  logic [TAP_WIDTH-1:0] run_start_q, run_start_d;
  logic [TAP_WIDTH:0]   run_len_q, run_len_d;
  logic [TAP_WIDTH-1:0] best_start_q, best_start_d;
  logic [TAP_WIDTH:0]   best_len_q, best_len_d;
  logic [TAP_WIDTH-1:0] tap_out_q, tap_out_d;
  logic                 tap_load_q, tap_load_d;
  logic                 locked_q, locked_d;
  logic                 error_q, error_d;
  logic [TAP_WIDTH-1:0] win_start_q, win_start_d;
  logic [TAP_WIDTH:0]   win_len_q, win_len_d;

  logic                 mismatch;
  logic                 restart;
  logic                 qualified;
  logic [TAP_WIDTH:0]   new_len;
  logic [TAP_WIDTH-1:0] new_start;

  assign mismatch  = (q1_i != PATTERN_Q1) || (q2_i != PATTERN_Q2);
  assign qualified = (best_len_q >= MIN_LEN);
  assign new_len   = fail_q ? '0 : (run_len_q + LEN_ONE);
  assign new_start = (run_len_q == '0) ? cur_tap_q : run_start_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_tap_q    <= '0;
      cnt_q        <= '0;
      fail_q       <= 1'b0;
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      tap_out_q    <= '0;
      tap_load_q   <= 1'b0;
      locked_q     <= 1'b0;
      error_q      <= 1'b0;
      win_start_q  <= '0;
      win_len_q    <= '0;
    end else begin
      state_q      <= state_d;
      cur_tap_q    <= cur_tap_d;
      cnt_q        <= cnt_d;
      fail_q       <= fail_d;
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      tap_out_q    <= tap_out_d;
      tap_load_q   <= tap_load_d;
      locked_q     <= locked_d;
      error_q      <= error_d;
      win_start_q  <= win_start_d;
      win_len_q    <= win_len_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_tap_d    = cur_tap_q;
    cnt_d        = cnt_q;
    fail_d       = fail_q;
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    tap_out_d    = tap_out_q;
    tap_load_d   = 1'b0;
    locked_d     = locked_q;
    error_d      = error_q;
    win_start_d  = win_start_q;
    win_len_d    = win_len_q;
    restart      = 1'b0;

    case (state_q)
      S_IDLE: restart = start_i;
      // tap_out and its load strobe become visible together on the next cycle
      S_SET_TAP: begin
        tap_out_d  = cur_tap_q;
        tap_load_d = 1'b1;
        cnt_d      = '0;
        state_d    = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        fail_d = fail_q | mismatch;
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == SAMPLE_LAST) begin
          cnt_d   = '0;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        run_len_d = new_len;
        if (!fail_q) begin
          run_start_d = new_start;
          // strict compare keeps the earliest window on ties
          if (new_len > best_len_q) begin
            best_len_d   = new_len;
            best_start_d = new_start;
          end
        end
        fail_d = 1'b0;
        if (cur_tap_q == LAST_TAP) begin
          state_d = S_APPLY;
        end else begin
          cur_tap_d = cur_tap_q + TAP_ONE;
          state_d   = S_SET_TAP;
        end
      end
      S_APPLY: begin
        tap_out_d   = qualified ?
                      TAP_WIDTH'({1'b0, best_start_q} + ((best_len_q - LEN_ONE) >> 1)) :
                      DEF_TAP;
        tap_load_d  = 1'b1;
        win_start_d = best_start_q;
        win_len_d   = best_len_q;
        locked_d    = qualified;
        error_d     = !qualified;
        state_d     = S_DONE;
      end
      S_DONE: begin
        restart = start_i;
`ifdef IDDR_TAP_CALIB_TRACK_EN
        if (locked_q) begin
          fail_d = fail_q | mismatch;
          cnt_d  = cnt_q + CNT_ONE;
          if (cnt_q == SAMPLE_LAST) begin
            cnt_d  = '0;
            fail_d = 1'b0;
            if (fail_q | mismatch) restart = 1'b1;
          end
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    if (restart) begin
      state_d      = S_SET_TAP;
      cur_tap_d    = '0;
      cnt_d        = '0;
      fail_d       = 1'b0;
      run_start_d  = '0;
      run_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
      locked_d     = 1'b0;
      error_d      = 1'b0;
    end
  end

  assign tap_out_o   = tap_out_q;
  assign tap_load_o  = tap_load_q;
  assign busy_o      = (state_q == S_SET_TAP) || (state_q == S_SETTLE) || (state_q == S_SAMPLE) ||
                       (state_q == S_EVAL) || (state_q == S_APPLY);
  assign done_o      = (state_q == S_DONE);
  assign locked_o    = locked_q;
  assign error_o     = error_q;
  assign win_start_o = win_start_q;
  assign win_len_o   = win_len_q;

endmodule

`default_nettype wire

// File: tb/tb_iddr_tap_calib.sv
// tb_iddr_tap_calib: directed vector table plus reset / mid-sweep-start sequences for iddr_tap_calib.
`default_nettype none

module tb_iddr_tap_calib;

  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [0:0]    q1_i = 1'b0;
  logic [0:0]    q2_i = 1'b0;
  logic [TW-1:0] tap_out_o;
  logic          tap_load_o, busy_o, done_o, locked_o, error_o;
  logic [TW-1:0] win_start_o;
  logic [TW:0]   win_len_o;

  iddr_tap_calib #(
    .WIDTH(1), .TAP_WIDTH(TW), .SETTLE_CYCLES(2), .SAMPLE_COUNT(4),
    .MIN_WINDOW(2), .DEFAULT_TAP(0)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .q1_i(q1_i), .q2_i(q2_i),
    .tap_out_o(tap_out_o), .tap_load_o(tap_load_o), .busy_o(busy_o),
    .done_o(done_o), .locked_o(locked_o), .error_o(error_o),
    .win_start_o(win_start_o), .win_len_o(win_len_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pass;
    bit         glitch;
    int         exp_start;
    int         exp_len;
    int         exp_tap;
    bit         exp_lock;
  } vec_t;

  vec_t       vecs[7];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         start_cyc = -1000;
  logic [7:0] pass_mask = 8'h00;
  bit         glitch_en = 1'b0;
  int         load_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Training-link model: the captured words depend on the tap currently in the delay line.
  always @(negedge clk) begin
    if (pass_mask[tap_out_o]) begin
      q1_i = 1'b1;
      q2_i = 1'b0;
    end else begin
      q1_i = tap_out_o[0];
      q2_i = tap_out_o[0];
    end
    if (glitch_en && (cyc - start_cyc) == 28) q2_i = 1'b1;
    if (tap_load_o) load_q.push_back(int'(tap_out_o));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start_i = 1'b0;
    load_q.delete();
  endtask

  task automatic run_vec(input vec_t v, input int mid_start);
    pass_mask = v.pass;
    glitch_en = v.glitch;
    pulse_start();
    @(negedge clk);
    chk("busy_after_start", busy_o, 1);
    chk("done_cleared", done_o, 0);
    chk("locked_cleared", locked_o, 0);
    while (!done_o && (cyc - start_cyc) < 200) begin
      if (mid_start >= 0 && (cyc - start_cyc) == mid_start) begin
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
      end
      @(negedge clk);
    end
    chk("done_latency", cyc - start_cyc, 65);
    @(negedge clk);
    chk("done_held", done_o, 1);
    chk("busy_in_done", busy_o, 0);
    chk("load_strobe_1cyc", tap_load_o, 0);
    chk("win_start", win_start_o, v.exp_start);
    chk("win_len", win_len_o, v.exp_len);
    chk("tap_out", tap_out_o, v.exp_tap);
    chk("locked", locked_o, v.exp_lock);
    chk("error", error_o, !v.exp_lock);
    chk("load_count", load_q.size(), 9);
    if (load_q.size() == 9) begin
      for (int k = 0; k < 8; k++) chk("load_seq_tap", load_q[k], k);
      chk("load_final_tap", load_q[8], v.exp_tap);
    end
    glitch_en = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'b0011_1100, 1'b0, 2, 4, 3, 1'b1};
    vecs[1] = '{8'b0110_0110, 1'b0, 1, 2, 1, 1'b1};
    vecs[2] = '{8'b0000_0000, 1'b0, 0, 0, 0, 1'b0};
    vecs[3] = '{8'b1110_0000, 1'b0, 5, 3, 6, 1'b1};
    vecs[4] = '{8'b0011_1100, 1'b1, 4, 2, 4, 1'b1};
    vecs[5] = '{8'b1111_1111, 1'b0, 0, 8, 3, 1'b1};
    vecs[6] = '{8'b0001_0000, 1'b0, 4, 1, 0, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_tap_out", tap_out_o, 0);
    chk("rst_tap_load", tap_load_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_locked", locked_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_win_len", win_len_o, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_busy", busy_o, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], -1);

    // Reset asserted while sampling tap 4 aborts the sweep without a final load.
    pass_mask = 8'b0011_1100;
    pulse_start();
    while ((cyc - start_cyc) < 36) @(negedge clk);
    chk("tap_before_rst", tap_out_o, 4);
    #2 rst = 1'b1;
    #1;
    chk("midrst_tap_out", tap_out_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_done", done_o, 0);
    chk("midrst_locked", locked_o, 0);
    chk("midrst_win_len", win_len_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    load_q.delete();
    repeat (80) @(negedge clk);
    chk("post_rst_no_load", load_q.size(), 0);
    chk("post_rst_done", done_o, 0);
    chk("post_rst_busy", busy_o, 0);

    // Fresh sweep with a stray start mid-sweep that must be ignored.
    run_vec(vecs[0], 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/iddr_tap_calib.md
Name: iddr_tap_calib

Overview:
- Calibration controller for the input DDR capture path.
- Sweeps a shared input-delay tap value across all codes while the link sends a known training pattern. At each tap it checks the captured rising-edge (q1) and falling-edge (q2) words against that pattern.
- Finds the widest contiguous passing window, then loads the window centre into the delay element.
- Sits between the DDR input flops and the delay-line control of the RGMII/GMII receive front end.

Parameters:
- WIDTH, 1, number of captured lanes (matches the DDR input register width).
- TAP_WIDTH, 5, width of the delay tap code; the sweep covers N = 2^TAP_WIDTH taps.
- SETTLE_CYCLES, 16, cycles waited after each tap load before sampling; must be >= 1.
- SAMPLE_COUNT, 256, compare cycles per tap; must be >= 1.
- MIN_WINDOW, 2, minimum passing window length (in taps) required to declare lock.
- DEFAULT_TAP, 0, tap code applied when calibration fails.
- PATTERN_Q1, {WIDTH{1'b1}}, expected q1 word during training.
- PATTERN_Q2, {WIDTH{1'b0}}, expected q2 word during training.

Ports:
- clk  in  1  system clock (the capture clock of the DDR input register).
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin calibration.
- q1  in  WIDTH  rising-edge data from the DDR input register.
- q2  in  WIDTH  falling-edge data from the DDR input register.
- tap_out  out  TAP_WIDTH  registered tap code sent to the delay element.
- tap_load  out  1  one-cycle strobe; the delay element loads tap_out.
- busy  out  1  high from the SET_TAP state through the APPLY state.
- done  out  1  high while in DONE.
- locked  out  1  high in DONE when a window >= MIN_WINDOW was found.
- error  out  1  high in DONE when no qualifying window was found.
- win_start  out  TAP_WIDTH  start tap of the best window.
- win_len  out  TAP_WIDTH+1  length of the best window, 0..N.

Behaviour:
- Clock and reset: one clock domain (clk); rst is asynchronous, active-high.
- Reset:
  - State goes to IDLE.
  - All outputs go to 0, including tap_out.
  - All counters and window trackers go to 0.
  - Reset asserted mid-sweep aborts immediately; no final tap_load is issued.
- IDLE / DONE:
  - start = 1 moves the FSM to SET_TAP with cur_tap = 0.
  - On that transition, done, locked and error are cleared and the window trackers are reset.
  - start is ignored in every other state.
- SET_TAP (1 cycle): tap_out <= cur_tap; tap_load = 1. Next state is SETTLE.
- SETTLE (SETTLE_CYCLES cycles): no comparisons are made. Next state is SAMPLE.
- SAMPLE (SAMPLE_COUNT cycles):
  - Each cycle, fail is set if q1 != PATTERN_Q1 or q2 != PATTERN_Q2 on any lane.
  - fail is sticky for the current tap.
  - Next state is EVAL.
- EVAL (1 cycle):
  - Pass (fail = 0): if run_len = 0, then run_start <= cur_tap. run_len increments.
  - Fail (fail = 1): run_len <= 0.
  - The best window is replaced only when the run length, counting this tap's update, is strictly greater than best_len. This makes the earliest window win ties.
  - A window still running at tap N-1 is closed at N-1; there is no wrap to tap 0.
  - fail is cleared.
  - If cur_tap = N-1, next state is APPLY. Otherwise cur_tap increments and next state is SET_TAP.
- APPLY (1 cycle):
  - If best_len >= MIN_WINDOW: tap_out <= best_start + (best_len-1)/2 (integer floor).
  - Otherwise: tap_out <= DEFAULT_TAP.
  - tap_load = 1. win_start and win_len are updated from best_start and best_len.
  - Next state is DONE.
- DONE: locked = (best_len >= MIN_WINDOW); error = !locked; busy = 0.
- Latency:
  - Per-tap period P = SETTLE_CYCLES + SAMPLE_COUNT + 2 cycles.
  - done rises N*P + 1 cycles after the clock edge that captures start.
- Width rule: the best_start + (best_len-1)/2 arithmetic is done at TAP_WIDTH+1 bits. The result is always <= N-1, so it is truncated to TAP_WIDTH bits.

Optional Feature:
- Macro: IDDR_TAP_CALIB_TRACK_EN.
- Defined:
  - While locked in DONE, the block compares continuously over successive SAMPLE_COUNT-cycle windows.
  - Any window containing a mismatch clears locked and automatically restarts the sweep from tap 0, exactly as if start had been asserted.
  - error stays 0 during the restart.
- Not defined: DONE is static; locked holds until the next start or rst.

Test Plan:
All scenarios use TAP_WIDTH=3, SETTLE_CYCLES=2, SAMPLE_COUNT=4, MIN_WINDOW=2, DEFAULT_TAP=0, which gives P=8 and done 65 cycles after start.
- Pattern correct only at taps 2..5 -> tap_load pulses at taps 0..7, then a final load; win_start=2, win_len=4, tap_out=3, locked=1, error=0, done exactly 65 cycles after start.
- Passing taps 1..2 and 5..6 (tie) -> win_start=1, win_len=2, tap_out=1, locked=1.
- All taps fail -> win_len=0, tap_out=0, locked=0, error=1, done=1.
- Passing taps 5..7 -> win_start=5, win_len=3, tap_out=6; the window at the last tap is closed without wrap.
- Passing taps 2..5 plus a single q2 glitch in one SAMPLE cycle of tap 3 -> win_start=4, win_len=2, tap_out=4.
- rst pulsed during SAMPLE of tap 4 -> all outputs 0, state IDLE, no further tap_load. A new start then completes normally, and a start asserted mid-sweep is ignored.
